// File: rtl/if_id_queue_pkg.sv
// Types shared by the IF/ID instruction queue: occupancy states and the stored entry.
`include "if_id_queue_defines.sv"

package if_id_queue_pkg;

    localparam int ENTRY_WIDTH = `INST_WIDTH + `SYS_ADDR_SPACE + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } ifq_state_e;

    typedef struct packed {
        logic [`INST_WIDTH-1:0]     inst;
        logic [`SYS_ADDR_SPACE-1:0] pc;
        logic                       anomaly;
    } ifq_entry_t;

    function automatic ifq_entry_t nop_entry();
        ifq_entry_t e;
        e.inst    = `INST_NOP;
        e.pc      = '0;
        e.anomaly = `Off;
        return e;
    endfunction

endpackage

// File: rtl/if_id_queue_defines.sv
// Shared core-wide defines: instruction/address widths, the canonical NOP word and On/Off levels.
// Guarded so every file may include it regardless of compile order.
`ifndef IF_ID_QUEUE_DEFINES_SV
`define IF_ID_QUEUE_DEFINES_SV

`define INST_WIDTH     32
`define SYS_ADDR_SPACE 32
`define INST_NOP       32'h00000013
`define On             1'b1
`define Off            1'b0

`endif

// File: rtl/if_id_queue_mem.sv
// ifq_mem: DEPTH-entry register array, one write port, one asynchronous read port.
// Synchronous clear to NOP entries on rst_i.
`include "if_id_queue_defines.sv"

module ifq_mem
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  ifq_entry_t    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output ifq_entry_t    rdata_o
);

    ifq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= nop_entry();
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer between fetch and decode with flush and stall.
// Optional macro IFQ_BYPASS_EN lets an empty queue forward the incoming word in the same cycle.
//
// state      | meaning
// ST_EMPTY   | count == 0, outputs idle (NOP)
// ST_PARTIAL | 0 < count < DEPTH
// ST_FULL    | count == DEPTH, fetch must hold its PC
`include "if_id_queue_defines.sv"

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic [`INST_WIDTH-1:0]     inst_i,
    input  logic [`SYS_ADDR_SPACE-1:0] pc_i,
    input  logic                       anomaly_i,
    input  logic                       flush_i,
    input  logic                       stall_i,
    output logic                       full_o,
    output logic                       valid_o,
    output logic [`INST_WIDTH-1:0]     inst_o,
    output logic [`SYS_ADDR_SPACE-1:0] pc_o,
    output logic                       anomaly_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    ifq_state_e state_q, state_d;
    cnt_t       count_q, count_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;

    ifq_entry_t wr_entry, rd_entry;
    logic       stored_valid, bypass, push, pop;

    assign stored_valid = (count_q != '0);
    assign full_o       = (state_q == ST_FULL);

`ifdef IFQ_BYPASS_EN
    assign bypass = (state_q == ST_EMPTY) && valid_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that decode takes immediately is never stored.
    assign push = valid_i && !full_o && !flush_i && !(bypass && !stall_i);
    assign pop  = stored_valid && !stall_i && !flush_i;

    assign wr_entry = '{inst: inst_i, pc: pc_i, anomaly: anomaly_i};

    ifq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        if (count_d == '0)           state_d = ST_EMPTY;
        else if (count_d == CNT_FULL) state_d = ST_FULL;
        else                          state_d = ST_PARTIAL;
    end

    always_comb begin
        valid_o   = 1'b0;
        inst_o    = `INST_NOP;
        pc_o      = '0;
        anomaly_o = `Off;
        if (stored_valid) begin
            valid_o   = 1'b1;
            inst_o    = rd_entry.inst;
            pc_o      = rd_entry.pc;
            anomaly_o = rd_entry.anomaly;
        end else if (bypass) begin
            valid_o   = 1'b1;
            inst_o    = inst_i;
            pc_o      = pc_i;
            anomaly_o = anomaly_i;
        end
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of instruction entries; power of two, >=2.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 valid_i  in  1  fetch stage presents a fetched instruction this cycle.
REQ-005 inst_i  in  `INST_WIDTH  fetched instruction word.
REQ-006 pc_i  in  `SYS_ADDR_SPACE  PC of inst_i.
REQ-007 anomaly_i  in  1  fetch flagged instruction as non-32-bit encoding (inst[1:0]!=2'b11).
REQ-008 flush_i  in  1  branch-unit redirect; discard all queued and incoming entries.
REQ-009 stall_i  in  1  hazard unit: decode cannot accept an instruction this cycle.
REQ-010 full_o  out  1  queue holds DEPTH entries; fetch stage SHALL hold its PC.
REQ-011 valid_o  out  1  inst_o/pc_o/anomaly_o carry a real instruction.
REQ-012 inst_o  out  `INST_WIDTH  instruction to decode.
REQ-013 pc_o  out  `SYS_ADDR_SPACE  PC of inst_o.
REQ-014 anomaly_o  out  1  anomaly flag travelling with inst_o.

Function
REQ-015 Storage: circular buffer of DEPTH entries {inst, pc, anomaly}; write pointer, read pointer, count 0..DEPTH.
REQ-016 Occupancy states EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count DEPTH); full_o = (state==FULL).
REQ-017 Push = valid_i && !full_o && !flush_i; writes entry at write pointer, pointer increments modulo DEPTH.
REQ-018 Pop = valid_o && !stall_i && !flush_i; read pointer increments modulo DEPTH.
REQ-019 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-020 Push while FULL is ignored; no entry overwritten, count stays DEPTH.
REQ-021 Pop is never generated while EMPTY; count never underflows.
REQ-022 Latency: pushed entry appears on outputs the cycle after the push edge (registered path).
REQ-023 valid_o = (count!=0); outputs show entry at read pointer, in push order.
REQ-024 When valid_o=0, inst_o = `INST_NOP (32'h00000013), pc_o = 0, anomaly_o = 0.
REQ-025 flush_i wins over push, pop and stall: next cycle count=0, pointers=0, valid_o=0, full_o=0.
REQ-026 stall_i holds outputs stable while valid_o=1; push still accepted if not FULL.

Reset
REQ-027 rst_i asserted at an edge: count=0, pointers=0, state EMPTY, all entries cleared to NOP/0/0.
REQ-028 After reset: valid_o=0, full_o=0, inst_o=`INST_NOP, pc_o=0, anomaly_o=0; rst_i overrides push/pop/flush, including mid-operation.

Configuration
REQ-029 Macro IFQ_BYPASS_EN: when defined and state EMPTY with valid_i=1, flush_i=0, inputs drive outputs combinationally in the same cycle with valid_o=1; if stall_i=0 the word is consumed and not stored, else it is pushed.
REQ-030 Without IFQ_BYPASS_EN: no combinational input-to-output path; REQ-022 latency of one cycle applies always.

Structure
REQ-031 `INST_WIDTH, `SYS_ADDR_SPACE, `INST_NOP, `On/`Off live in the shared defines file; no local redefinition.
REQ-032 One sub-module ifq_mem: DEPTH-entry register array, one write port, one asynchronous read port, synchronous clear on rst_i.
REQ-033 Pointer/count/state logic and bypass mux stay in if_id_queue.

Verification
REQ-034 Reset: hold rst_i 2 cycles, release -> valid_o=0, full_o=0, inst_o=32'h00000013, pc_o=0.
REQ-035 Fill/drain: stall_i=1, push pc 0x0,0x4 -> full_o=1 after 2nd edge, 3rd push (0x8) dropped; release stall -> pcs out 0x0,0x4 then valid_o=0.
REQ-036 Streaming: valid_i=1 every cycle, stall_i=0, pcs 0x0..0x1C -> same order out, one-cycle lag, count stays 1, full_o never 1.
REQ-037 Flush: queue holds 2, flush_i=1 with valid_i=1 (pc 0x40) -> next cycle valid_o=0, count 0; pc 0x40 never appears.
REQ-038 Anomaly: push inst 32'h00004501 with anomaly_i=1 -> emerges with anomaly_o=1 and pc intact.
REQ-039 Bypass (IFQ_BYPASS_EN): EMPTY, valid_i=1 pc 0x100, stall_i=0 -> same-cycle valid_o=1, pc_o=0x100, count stays 0.
